// File: rtl/jk_q_monitor.sv
// Monitors the q/q1 outputs of a JK flip-flop: edge pulses, toggle count,
// run-length tracking and a sticky complement-fault detector.
module jk_q_monitor #(
  parameter int CNT_W = 8,
  parameter int RUN_W = 8
) (
  input  logic             c,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             q,
  input  logic             q1,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [RUN_W-1:0] run_len,
  output logic [RUN_W-1:0] max_run,
  output logic             comp_err,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_LOW   = 2'b01,
    ST_HIGH  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [RUN_W-1:0] max_q, max_d;
  logic             err_q, err_d;

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
      run_q   <= '0;
      max_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      max_q   <= max_d;
      err_q   <= err_d;
    end
  end

  // The complement check is evaluated before the transition test so a
  // simultaneous edge-plus-fault lands in FAULT without pulsing or counting.
  always_comb begin
    state_d = state_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    cnt_d   = cnt_q;
    run_d   = run_q;
    max_d   = max_q;
    err_d   = err_q;
    if (clr) begin
      state_d = ST_INIT;
      cnt_d   = '0;
      run_d   = '0;
      max_d   = '0;
      err_d   = 1'b0;
    end else if (en) begin
      case (state_q)
        ST_INIT: begin
          if (q == q1) begin
            state_d = ST_FAULT;
            err_d   = 1'b1;
          end else begin
            state_d = q ? ST_HIGH : ST_LOW;
            run_d   = RUN_W'(1);
          end
        end
        ST_LOW, ST_HIGH: begin
          if (q == q1) begin
            state_d = ST_FAULT;
            err_d   = 1'b1;
          end else if (q == (state_q == ST_HIGH)) begin
            if (run_q != {RUN_W{1'b1}}) run_d = run_q + RUN_W'(1);
          end else begin
            rise_d  = (state_q == ST_LOW);
            fall_d  = (state_q == ST_HIGH);
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
            if (run_q > max_q) max_d = run_q;
            run_d   = RUN_W'(1);
            state_d = (state_q == ST_LOW) ? ST_HIGH : ST_LOW;
          end
        end
        default: ;
      endcase
    end
  end

  assign rise       = rise_q;
  assign fall       = fall_q;
  assign toggle_cnt = cnt_q;
  assign run_len    = run_q;
  assign max_run    = max_q;
  assign comp_err   = err_q;
  assign state      = state_q;

endmodule

// File: doc/jk_q_monitor.md
Name: jk_q_monitor

Overview:
- Downstream stage of jk_flipflop. Consumes its q/q1 outputs on the same clock.
- Detects rising and falling transitions of q and counts toggles.
- Measures how many cycles q holds each value and tracks the longest hold.
- Checks that q1 is always the complement of q, and latches a sticky fault if it is not.

Parameters:
CNT_W, 8, width of toggle counter (saturating)
RUN_W, 8, width of run-length and max-run registers (saturating)

Ports:
c  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
en  input  1  sample enable; 0 = freeze all state, pulses forced 0
clr  input  1  synchronous clear of counters, fault and FSM; priority over en
q  input  1  flip-flop true output
q1  input  1  flip-flop complement output
rise  output  1  one-cycle pulse: q sampled 0->1
fall  output  1  one-cycle pulse: q sampled 1->0
toggle_cnt  output  CNT_W  number of q transitions since reset/clr
run_len  output  RUN_W  cycles q has held its current value, including the current cycle
max_run  output  RUN_W  longest completed run since reset/clr
comp_err  output  1  sticky: q==q1 was sampled
state  output  2  FSM state: 00 INIT, 01 LOW, 10 HIGH, 11 FAULT

Behaviour:
- Reset (rst_n=0, asynchronous): state=INIT. rise, fall, toggle_cnt, run_len, max_run and comp_err are all 0.
- All outputs are registered. Inputs are sampled at the rising edge of c; results are visible after that same edge.
- clr=1 at an edge: same values as reset, applied regardless of en.
- en=0 (and clr=0): every register holds; rise=fall=0.
- INIT, en=1:
  - q==q1 -> FAULT, comp_err=1.
  - Otherwise -> LOW if q=0, HIGH if q=1, run_len=1.
  - No rise/fall pulse and no count on the first sample.
- LOW/HIGH, en=1: checks are applied in this order.
  - Complement check first: q==q1 -> FAULT, comp_err=1. No pulse, no count; run_len and max_run hold. This rule wins over a simultaneous transition.
  - q equals the value of the current state: run_len increments, saturating at 2^RUN_W-1. rise=fall=0.
  - q differs from the current state:
    - Pulse rise (LOW->HIGH) or fall (HIGH->LOW) for exactly one cycle.
    - toggle_cnt increments, saturating at 2^CNT_W-1; it never wraps.
    - If run_len > max_run, then max_run takes run_len (the completed run).
    - run_len=1; state flips.
- FAULT: all counters and flags hold, pulses are 0. Exit only via clr or rst_n.
- rise and fall are never high together.
- rst_n asserted mid-run clears immediately, without waiting for c.
- Release of rst_n is assumed synchronous to c, so no metastability handling is required.
- Saturated run_len still participates in the max_run compare; max_run saturates by construction.

Test Plan:
1. Reset, then en=1 with q=0,q1=1 for 3 cycles -> state=LOW (01), run_len=1,2,3; toggle_cnt=0; no pulses.
2. From test 1, q=1,q1=0 for 2 cycles, then back to q=0 -> expected responses:
   - rise pulses once at the first high sample, toggle_cnt=1, max_run=3, run_len=1.
   - Then fall pulses once, toggle_cnt=2, max_run=3.
3. Drive a free-running toggle of q (period 2 cycles) for 300 cycles with CNT_W=8 -> toggle_cnt stops at 255; rise and fall alternate; max_run=1 after the first transition.
4. Hold q=1,q1=0 for 300 cycles with RUN_W=8 -> run_len saturates at 255; on the next toggle max_run=255.
5. While in HIGH, drive q=0,q1=0 (transition plus complement fault in the same cycle) -> state=FAULT, comp_err=1, no fall pulse, toggle_cnt unchanged. Further toggles are ignored. clr=1 for one cycle -> all outputs 0, state=INIT.
6. Mid-run (toggle_cnt=5), cover three events:
   - en=0 for 4 cycles while q toggles -> all outputs frozen, pulses 0.
   - en=1 again, then pulse rst_n low between clock edges -> outputs clear immediately, without waiting for c.
   - clr and en both high on one edge -> clear wins.
